ticket_sequencer: RTL

Sequencing controller for one lottery ticket. It collects four bet numbers from successive scan strobes and validates each one. It then time-shares a single comparator against the four winning numbers, one bet per cycle. It finishes by presenting a payout request that is held until the cash stage acknowledges it. It sits between the scanner input, the winning-number source (SYSRDY) and the cash stage.

---
 rtl/ticket_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ticket_sequencer.sv
// ticket_sequencer
//   Sequencing controller for one lottery ticket. Collects four distinct
//   bet numbers from scan strobes, compares them one per cycle against
//   latched winning numbers, then holds a payout request until the cash
//   stage acknowledges it.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   SYSRDY     in   winning numbers valid
//   scan       in   single-cycle strobe, N_in holds a bet number
//   N_in[4:0]  in   scanned bet number
//   W1..W4     in   winning numbers (5 bits each)
//   ack        in   payout accepted / error cleared
//   busy       out  ticket in progress (state != IDLE)
//   bet_idx    out  index of bet being stored or compared
//   RD_ERR     out  ticket rejected
//   match_cnt  out  matches counted (0..4)
//   pay_req    out  payout valid
//   payout     out  payout amount in euros
//   winner     out  2+ matches, valid while pay_req
//   not_a_win  out  fewer than 2 matches, valid while pay_req
module ticket_sequencer #(
    parameter int MAX_NUM = 25,
    parameter int TIMEOUT = 200,
    parameter int PAY2    = 5,
    parameter int PAY3    = 50,
    parameter int PAY4    = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SYSRDY,
    input  logic       scan,
    input  logic [4:0] N_in,
    input  logic [4:0] W1,
    input  logic [4:0] W2,
    input  logic [4:0] W3,
    input  logic [4:0] W4,
    input  logic       ack,
    output logic       busy,
    output logic [1:0] bet_idx,
    output logic       RD_ERR,
    output logic [2:0] match_cnt,
    output logic       pay_req,
    output logic [9:0] payout,
    output logic       winner,
    output logic       not_a_win
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_COMPARE, S_PAYOUT, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    bet_q [4];
    logic [4:0]    bet_d [4];
    logic [4:0]    w_q   [4];
    logic [4:0]    w_d   [4];
    logic [4:0]    w_in  [4];
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    match_q, match_d;
    logic          hit_q, hit_d;          // registered comparator result
    logic          last_q, last_d;        // bet 3 has been compared
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic [9:0]    pay_q, pay_d;
    logic          win_q, win_d;
    logic          nowin_q, nowin_d;

    logic [3:0]    dup_vec;
    logic [3:0]    hit_vec;
    logic          num_ok;

    assign w_in[0] = W1;
    assign w_in[1] = W2;
    assign w_in[2] = W3;
    assign w_in[3] = W4;

    // Duplicate check only against bets already accepted (index below
    // bet_idx); the single comparator checks the current bet against all
    // four latched winning numbers.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_cmp
        assign dup_vec[gi] = (2'(gi) < idx_q) && (bet_q[gi] == N_in);
        assign hit_vec[gi] = (w_q[gi] == bet_q[idx_q]);
    end

    assign num_ok = (N_in != 5'd0) && (int'(N_in) <= MAX_NUM) && !(|dup_vec);

    function automatic logic [9:0] pay_of(input logic [2:0] m);
        case (m)
            3'd2:    pay_of = 10'(PAY2);
            3'd3:    pay_of = 10'(PAY3);
            3'd4:    pay_of = 10'(PAY4);
            default: pay_of = 10'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        bet_d   = bet_q;
        w_d     = w_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        match_d = match_q;
        hit_d   = hit_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (scan && SYSRDY) begin
                    if (num_ok) begin
                        bet_d[0] = N_in;
                        idx_d    = 2'd1;
                        timer_d  = '0;
                        state_d  = S_COLLECT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_COLLECT: begin
                if (!SYSRDY) begin
                    state_d = S_ERR;
                end else if (scan) begin
                    if (num_ok) begin
                        bet_d[idx_q] = N_in;
                        timer_d      = '0;
                        if (idx_q == 2'd3) begin
                            w_d     = w_in;
                            match_d = '0;
                            idx_d   = '0;
                            hit_d   = 1'b0;
                            last_d  = 1'b0;
                            state_d = S_COMPARE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_COMPARE: begin
                // Comparator result is registered, so the count trails the
                // bet index by one cycle; the extra cycle flushes bet 3.
                match_d = match_q + 3'(hit_q);
                if (last_q) begin
                    hit_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_PAYOUT;
                end else begin
                    hit_d = |hit_vec;
                    if (idx_q == 2'd3) last_d = 1'b1;
                    else               idx_d  = idx_q + 2'd1;
                end
            end
            S_PAYOUT, S_ERR: begin
                if (ack) begin
                    state_d = S_IDLE;
                    for (int i = 0; i < 4; i++) begin
                        bet_d[i] = '0;
                        w_d[i]   = '0;
                    end
                    timer_d = '0;
                    idx_d   = '0;
                    match_d = '0;
                    hit_d   = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies decoded from the next state.
        busy_d  = (state_d != S_IDLE);
        err_d   = (state_d == S_ERR);
        req_d   = (state_d == S_PAYOUT);
        pay_d   = (state_d == S_PAYOUT) ? pay_of(match_d) : 10'd0;
        win_d   = (state_d == S_PAYOUT) && (match_d >= 3'd2);
        nowin_d = (state_d == S_PAYOUT) && (match_d <  3'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                bet_q[i] <= '0;
                w_q[i]   <= '0;
            end
            timer_q <= '0;
            idx_q   <= '0;
            match_q <= '0;
            hit_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            pay_q   <= '0;
            win_q   <= 1'b0;
            nowin_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bet_q   <= bet_d;
            w_q     <= w_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            hit_q   <= hit_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            req_q   <= req_d;
            pay_q   <= pay_d;
            win_q   <= win_d;
            nowin_q <= nowin_d;
        end
    end

    assign busy      = busy_q;
    assign bet_idx   = idx_q;
    assign RD_ERR    = err_q;
    assign match_cnt = match_q;
    assign pay_req   = req_q;
    assign payout    = pay_q;
    assign winner    = win_q;
    assign not_a_win = nowin_q;

endmodule
